// File: rtl/push_pop_sequencer.sv
// push_pop_sequencer
//   Breaks a Thumb PUSH/POP instruction into single-register stack micro-ops.
//   PUSH is issued in descending order (LR, r7..r0), each one a store to
//   [SP-4] with SP pre-decrement. POP is issued in ascending order (r0..r7, PC),
//   each one a load from [SP] with SP post-increment.
//
// Configuration macro: PPSEQ_LRPC_EN
//   defined   -> R bit (instr_i[8]) adds LR to PUSH / PC to POP
//   undefined -> R bit ignored, uop_pc_load_o tied low
//
// Ports
//   clk_i          in   rising-edge clock
//   rst_ni         in   asynchronous active-low reset
//   instr_i[15:0]  in   instruction word from decode
//   instr_valid_i  in   instr_i valid
//   instr_ready_o  out  sequencer idle, can accept instr_i
//   uop_valid_o    out  micro-op valid
//   uop_ready_i    in   datapath consumes current micro-op
//   uop_reg_o[3:0] out  micro-op register (0-7, 14=LR, 15=PC)
//   uop_store_o    out  store micro-op (PUSH)
//   uop_load_o     out  load micro-op (POP)
//   uop_pc_load_o  out  load micro-op targets PC
//   done_o         out  one-cycle pulse, sequence complete
//   err_o          out  one-cycle pulse, empty register list
module push_pop_sequencer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic        uop_valid_o,
  input  logic        uop_ready_i,
  output logic [3:0]  uop_reg_o,
  output logic        uop_store_o,
  output logic        uop_load_o,
  output logic        uop_pc_load_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2
  } state_t;

`ifdef PPSEQ_LRPC_EN
  localparam logic [8:0] LIST_MASK = 9'h1FF;
`else
  localparam logic [8:0] LIST_MASK = 9'h0FF;
`endif

  state_t     r_state;
  logic [8:0] r_mask;     // bit 8 = LR (PUSH) / PC (POP), bits 7:0 = r7..r0
  logic       r_done;
  logic       r_err;

  logic       w_dec_ok;
  logic [8:0] w_list;
  logic [3:0] w_sel_idx;
  logic [8:0] w_sel_oh;
  logic [8:0] w_mask_next;
  logic [3:0] w_reg;
  logic       w_busy;

  assign w_dec_ok = (instr_i[15:12] == 4'b1011) && (instr_i[10:9] == 2'b10);
  assign w_list   = instr_i[8:0] & LIST_MASK;
  assign w_busy   = (r_state != S_IDLE);

  // PUSH takes the highest pending bit, POP the lowest: the loop lets the
  // last matching bit win, so the scan direction flips with the state.
  always_comb begin
    w_sel_idx = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (r_state == S_POP) begin
        if (r_mask[8 - i]) w_sel_idx = 4'(8 - i);
      end else begin
        if (r_mask[i]) w_sel_idx = 4'(i);
      end
    end
  end

  assign w_sel_oh    = 9'b1 << w_sel_idx;
  assign w_mask_next = r_mask & ~w_sel_oh;

  always_comb begin
    w_reg = w_sel_idx;
    if (w_sel_idx == 4'd8) w_reg = (r_state == S_POP) ? 4'd15 : 4'd14;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid_i && w_dec_ok) begin
            if (w_list != '0) begin
              r_mask  <= w_list;
              r_state <= instr_i[11] ? S_POP : S_PUSH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_PUSH, S_POP: begin
          if (uop_ready_i) begin
            r_mask <= w_mask_next;
            if (w_mask_next == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mask  <= '0;
        end
      endcase
    end
  end

  assign instr_ready_o = !w_busy;
  assign uop_valid_o   = w_busy;
  assign uop_reg_o     = w_busy ? w_reg : 4'd0;
  assign uop_store_o   = (r_state == S_PUSH);
  assign uop_load_o    = (r_state == S_POP);
`ifdef PPSEQ_LRPC_EN
  assign uop_pc_load_o = (r_state == S_POP) && (w_sel_idx == 4'd8);
`else
  assign uop_pc_load_o = 1'b0;
`endif
  assign done_o        = r_done;
  assign err_o         = r_err;

endmodule
